dyn_branch_predictor: RTL
=========================

// Module: dyn_branch_predictor
// PURPOSE
//   Parametrised dynamic branch predictor for the fetch stage: tagged BTB plus per-entry
//   saturating-counter BHT, both sized by parameter. Gives a same-cycle prediction for PC_curr.
//   Takes resolved-branch updates from decode and drives the fetch redirect (PC update).
//   Keeps saturating branch and mispredict statistics counters.
// PARAMETERS
//   ADDR_W  16  PC/target width
//   IDX_W   4   table index bits; tables hold 2**IDX_W entries
//   TAG_W   4   BTB tag bits, taken from PC[IDX_W+TAG_W:IDX_W+1]
//   CNT_W   2   BHT counter width (>=2); taken = counter MSB
// PORTS
//   clk              in   1       clock
//   rst              in   1       reset, synchronous, active-low
//   PC_curr          in   ADDR_W  fetch PC for lookup
//   lookup_idx       out  IDX_W   index used for this lookup; decode returns it as upd_idx
//   prediction       out  CNT_W   BHT counter value at lookup_idx
//   predicted_taken  out  1       prediction[CNT_W-1] & btb_hit
//   predicted_target out  ADDR_W  BTB target on hit, else 0
//   btb_hit          out  1       valid[idx] & tag match
//   upd_valid        in   1       decode resolved a branch this cycle
//   upd_idx          in   IDX_W   lookup_idx pipelined with the branch
//   upd_PC           in   ADDR_W  PC of the resolved branch
//   upd_taken        in   1       actual direction
//   upd_target       in   ADDR_W  actual target
//   upd_pred_taken   in   1       predicted_taken pipelined with the branch
//   upd_pred_target  in   ADDR_W  predicted_target pipelined with the branch
//   redirect         out  1       mispredict; fetch must load redirect_PC
//   redirect_PC      out  ADDR_W  upd_taken ? upd_target : upd_PC+2 (mod 2**ADDR_W)
//   br_count         out  16      resolved branches, saturates at 16'hFFFF
//   mispred_count    out  16      redirects, saturates at 16'hFFFF
// BEHAVIOUR
//   - Lookup is combinational from the flop arrays. idx = PC_curr[IDX_W:1]
//     (halfword aligned; GSHARE_EN modifies it). No read-during-write bypass: a lookup
//     at the idx being updated returns the pre-update value.
//   - rst==0 at posedge: all BHT counters <= 0 (strongly not-taken), all BTB valid <= 0,
//     tags/targets <= 0, br_count <= 0, mispred_count <= 0, GHR <= 0.
//     Reset wins over a simultaneous upd_valid.
//   - After reset: btb_hit=0, predicted_taken=0, predicted_target=0, prediction=0.
//   - mispredict = upd_valid & ((upd_pred_taken != upd_taken)
//                  | (upd_taken & upd_pred_target != upd_target)).
//   - redirect = mispredict, combinational, same cycle. redirect_PC is valid only while redirect=1.
//   - On posedge with upd_valid & rst:
//       BHT[upd_idx]: +1 if upd_taken, -1 if not; saturates at 2**CNT_W-1 and at 0.
//       if upd_taken: valid[upd_idx] <= 1, tag <= upd_PC tag bits, target <= upd_target
//         (overwrites any aliasing entry). Not-taken updates leave the BTB unchanged.
//       br_count +1 (sat); if mispredict, mispred_count +1 (sat).
//   - upd_valid=0: no state change. All updates are single-cycle; no handshake and no back-pressure.
// CONFIGURATION
//   GSHARE_BHT_EN defined: IDX_W-bit global history register GHR.
//     On each upd_valid, GHR <= {GHR[IDX_W-2:0], upd_taken}.
//     BHT index = PC_curr[IDX_W:1] ^ GHR; lookup_idx reports this XORed index.
//     BTB index stays PC_curr[IDX_W:1].
//     The BHT update uses upd_idx. The BTB update uses upd_PC[IDX_W:1].
//   Not defined: no GHR; BHT and BTB share idx = PC_curr[IDX_W:1]; lookup_idx is that index.
// TESTING
//   1 rst=0 one cycle, then PC_curr=16'h0004 -> btb_hit=0, prediction=0, predicted_taken=0, target=0.
//   2 Two updates at PC 16'h0004, taken, target 16'h0040, pred_taken=0
//     -> redirect=1, redirect_PC=16'h0040 both cycles; then lookup 16'h0004
//     -> prediction=2'b10, hit=1, target=16'h0040.
//   3 Five taken updates on one idx -> counter saturates at 2'b11;
//     one not-taken -> 2'b10, redirect_PC=upd_PC+2.
//   4 Alias: taken update at 16'h0004 then at 16'h0024 (same idx, different tag)
//     -> lookup 16'h0004 btb_hit=0, predicted_taken=0.
//   5 upd_pred_taken=1, upd_taken=1, pred_target 16'h0040 != target 16'h0080
//     -> redirect=1, redirect_PC=16'h0080, mispred_count +1.
//   6 upd_valid with rst=0 in the same cycle -> counters and tables read as reset values next cycle.
//     With GSHARE_BHT_EN: after updates T,T,N, GHR=4'b0110 and lookup_idx = PC[4:1]^4'b0110.

Source files
------------

// File: rtl/dyn_branch_predictor.sv
// Dynamic branch predictor: tagged BTB plus per-entry saturating-counter BHT, with fetch redirect and statistics.
// Latency: lookup and redirect are combinational; table, history and counter updates land on the next clk edge.
// Backpressure: none; every upd_valid cycle is absorbed in one cycle. Optional GSHARE_BHT_EN adds global history to the BHT index.
module dyn_branch_predictor #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC_curr,
  output logic [IDX_W-1:0]  lookup_idx,
  output logic [CNT_W-1:0]  prediction,
  output logic              predicted_taken,
  output logic [ADDR_W-1:0] predicted_target,
  output logic              btb_hit,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [ADDR_W-1:0] upd_PC,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_PC,
  output logic [15:0]       br_count,
  output logic [15:0]       mispred_count
);

  localparam int               ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0]      STAT_MAX = 16'hFFFF;

  // Prediction tables
  logic [CNT_W-1:0]  bht        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [ADDR_W-1:0] btb_target [ENTRIES];

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [TAG_W-1:0]  upd_tag;
  logic [IDX_W-1:0]  bht_rd_idx;
  logic [IDX_W-1:0]  btb_wr_idx;
  logic [CNT_W-1:0]  bht_cur;
  logic [CNT_W-1:0]  bht_next;
  logic              mispredict;

  // Only the index and tag fields of the PCs feed the tables; bit 0 and the
  // upper bits are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_curr, upd_PC};

  assign pc_idx  = PC_curr[IDX_W:1];
  assign pc_tag  = PC_curr[IDX_W+TAG_W:IDX_W+1];
  assign upd_tag = upd_PC[IDX_W+TAG_W:IDX_W+1];

`ifdef GSHARE_BHT_EN
  logic [IDX_W-1:0] ghr;

  // BHT is indexed by PC hashed with recent outcomes; the BTB keeps the plain
  // PC index, so its update index is re-derived from the branch PC.
  assign bht_rd_idx = pc_idx ^ ghr;
  assign btb_wr_idx = upd_PC[IDX_W:1];

  // Global history shifts in every resolved direction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[IDX_W-2:0], upd_taken};
    end
  end
`else
  assign bht_rd_idx = pc_idx;
  assign btb_wr_idx = upd_idx;
`endif

  assign lookup_idx = bht_rd_idx;

  // Combinational lookup straight from the flops; no write bypass.
  always_comb begin
    prediction       = bht[bht_rd_idx];
    btb_hit          = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
    predicted_taken  = prediction[CNT_W-1] & btb_hit;
    predicted_target = btb_hit ? btb_target[pc_idx] : '0;
  end

  // Resolution: direction wrong, or taken with the wrong target.
  always_comb begin
    mispredict  = upd_valid & ((upd_pred_taken != upd_taken) |
                               (upd_taken & (upd_pred_target != upd_target)));
    redirect    = mispredict;
    redirect_PC = upd_taken ? upd_target : (upd_PC + ADDR_W'(2));
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    bht_cur  = bht[upd_idx];
    bht_next = bht_cur;
    if (upd_taken) begin
      if (bht_cur != CNT_MAX) bht_next = bht_cur + CNT_W'(1);
    end else begin
      if (bht_cur != '0) bht_next = bht_cur - CNT_W'(1);
    end
  end

  // BHT and BTB state; reset clears everything and wins over an update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i]        <= '0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_valid) begin
      bht[upd_idx] <= bht_next;
      // Taken branches claim the BTB entry, evicting any aliasing branch.
      if (upd_taken) begin
        btb_valid[btb_wr_idx]  <= 1'b1;
        btb_tag[btb_wr_idx]    <= upd_tag;
        btb_target[btb_wr_idx] <= upd_target;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd_valid) begin
      if (br_count != STAT_MAX) br_count <= br_count + 16'd1;
      if (mispredict && (mispred_count != STAT_MAX)) mispred_count <= mispred_count + 16'd1;
    end
  end

endmodule
